// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB handshake and instruction payload bundle
interface wb_stage_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [1:0]  ms_memToReg;
  logic        ms_regwrite;
  logic        ms_HI_read;
  logic        ms_LO_read;
  logic        ms_HI_write;
  logic        ms_LO_write;
  logic        ms_hilo_src;
  logic [4:0]  ms_dest;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_hi_result;
  logic [31:0] ms_lo_result;
  logic        ms_is_load;
  logic [2:0]  ms_load_type;
  logic [31:0] ms_cp0_rdata;
  modport master (
    output ms_to_ws_valid, ms_pc, ms_memToReg, ms_regwrite, ms_HI_read, ms_LO_read,
           ms_HI_write, ms_LO_write, ms_hilo_src, ms_dest, ms_alu_result,
           ms_hi_result, ms_lo_result, ms_is_load, ms_load_type, ms_cp0_rdata,
    input  ws_allowin
  );
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_memToReg, ms_regwrite, ms_HI_read, ms_LO_read,
           ms_HI_write, ms_LO_write, ms_hilo_src, ms_dest, ms_alu_result,
           ms_hi_result, ms_lo_result, ms_is_load, ms_load_type, ms_cp0_rdata,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage owning HI/LO, load alignment and GPR write port
module wb_stage (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   ms,
  input  logic [31:0] data_sram_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_value,
  output logic [31:0] lo_value,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  logic        valid_q;
  logic [31:0] pc_q;
  logic [1:0]  mem_to_reg_q;
  logic        regwrite_q;
  logic        hi_read_q;
  logic        hi_write_q;
  logic        lo_write_q;
  logic        hilo_src_q;
  logic [4:0]  dest_q;
  logic [31:0] alu_q;
  logic [31:0] hi_res_q;
  logic [31:0] lo_res_q;
  logic        is_load_q;
  logic [2:0]  load_type_q;
  logic [31:0] cp0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] wdata;

  // WB never stalls, so it always accepts whatever MEM offers
  assign ms.ws_allowin = 1'b1;

  // Stage register: capture the MEM payload; a bubble only drops valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q      <= 1'b0;
      pc_q         <= 32'd0;
      mem_to_reg_q <= 2'd0;
      regwrite_q   <= 1'b0;
      hi_read_q    <= 1'b0;
      hi_write_q   <= 1'b0;
      lo_write_q   <= 1'b0;
      hilo_src_q   <= 1'b0;
      dest_q       <= 5'd0;
      alu_q        <= 32'd0;
      hi_res_q     <= 32'd0;
      lo_res_q     <= 32'd0;
      is_load_q    <= 1'b0;
      load_type_q  <= 3'd0;
      cp0_q        <= 32'd0;
    end else begin
      valid_q <= ms.ms_to_ws_valid;
      if (ms.ms_to_ws_valid) begin
        pc_q         <= ms.ms_pc;
        mem_to_reg_q <= ms.ms_memToReg;
        regwrite_q   <= ms.ms_regwrite;
        hi_read_q    <= ms.ms_HI_read;
        hi_write_q   <= ms.ms_HI_write;
        lo_write_q   <= ms.ms_LO_write;
        hilo_src_q   <= ms.ms_hilo_src;
        dest_q       <= ms.ms_dest;
        alu_q        <= ms.ms_alu_result;
        hi_res_q     <= ms.ms_hi_result;
        lo_res_q     <= ms.ms_lo_result;
        is_load_q    <= ms.ms_is_load;
        load_type_q  <= ms.ms_load_type;
        cp0_q        <= ms.ms_cp0_rdata;
      end
    end
  end

  // HI/LO commit at the end of the WB cycle so a following MFHI/MFLO sees the new value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (valid_q && hi_write_q) hi_q <= hilo_src_q ? hi_res_q : alu_q;
      if (valid_q && lo_write_q) lo_q <= hilo_src_q ? lo_res_q : alu_q;
    end
  end

  // Little-endian load extraction and write-back source selection
  always_comb begin
    byte_sel  = alu_q[1] ? (alu_q[0] ? data_sram_rdata[31:24] : data_sram_rdata[23:16])
                         : (alu_q[0] ? data_sram_rdata[15:8]  : data_sram_rdata[7:0]);
    half_sel  = alu_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    load_data = (load_type_q == 3'b001) ? {{24{byte_sel[7]}}, byte_sel} :
                (load_type_q == 3'b010) ? {24'd0, byte_sel} :
                (load_type_q == 3'b011) ? {{16{half_sel[15]}}, half_sel} :
                (load_type_q == 3'b100) ? {16'd0, half_sel} : data_sram_rdata;
    wdata     = (mem_to_reg_q == 2'b00) ? (is_load_q ? load_data : alu_q) :
                (mem_to_reg_q == 2'b01) ? (hi_read_q ? hi_q : lo_q) :
                (mem_to_reg_q == 2'b10) ? pc_q + 32'd8 : cp0_q;
  end

  assign rf_we             = valid_q && regwrite_q && (dest_q != 5'd0);
  assign rf_waddr          = dest_q;
  assign rf_wdata          = wdata;
  assign hi_value          = hi_q;
  assign lo_value          = lo_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed-vector self-checking bench for wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] data_sram_rdata = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi_value;
  logic [31:0] lo_value;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  int vectors = 0;
  int errs = 0;

  wb_stage_if bus ();

  wb_stage dut (
    .clk(clk), .resetn(resetn), .ms(bus.slave), .data_sram_rdata(data_sram_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_value(hi_value), .lo_value(lo_value), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.ms_to_ws_valid = 0; bus.ms_pc = 0; bus.ms_memToReg = 0; bus.ms_regwrite = 0;
    bus.ms_HI_read = 0; bus.ms_LO_read = 0; bus.ms_HI_write = 0; bus.ms_LO_write = 0;
    bus.ms_hilo_src = 0; bus.ms_dest = 0; bus.ms_alu_result = 0; bus.ms_hi_result = 0;
    bus.ms_lo_result = 0; bus.ms_is_load = 0; bus.ms_load_type = 0; bus.ms_cp0_rdata = 0;
  endtask

  task automatic issue();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] t, input logic [1:0] a);
    clr();
    bus.ms_to_ws_valid = 1; bus.ms_regwrite = 1; bus.ms_dest = 5'd8;
    bus.ms_is_load = 1; bus.ms_load_type = t; bus.ms_alu_result = {30'h0400_0000, a};
    issue();
  endtask

  initial begin
    clr();
    #3;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pc", debug_wb_pc, 32'd0);
    chk("rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    chk("rst_allowin", {31'd0, bus.ws_allowin}, 32'd1);
    chk("rst_hi", hi_value, 32'd0);
    chk("rst_lo", lo_value, 32'd0);
    #4 resetn = 1;
    issue();
    chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
    chk("idle_hi", hi_value, 32'd0);
    chk("idle_lo", lo_value, 32'd0);
    chk("idle_allowin", {31'd0, bus.ws_allowin}, 32'd1);

    bus.ms_to_ws_valid = 1; bus.ms_regwrite = 1; bus.ms_dest = 5'd5;
    bus.ms_alu_result = 32'h12345678; bus.ms_pc = 32'hBFC00010;
    issue();
    chk("addu_we", {31'd0, rf_we}, 32'd1);
    chk("addu_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("addu_wdata", rf_wdata, 32'h12345678);
    chk("addu_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
    chk("addu_wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);
    chk("addu_dwdata", debug_wb_rf_wdata, 32'h12345678);
    chk("addu_pc", debug_wb_pc, 32'hBFC00010);
    bus.ms_dest = 5'd0;
    issue();
    chk("addu_r0_we", {31'd0, rf_we}, 32'd0);
    chk("addu_r0_wen", {28'd0, debug_wb_rf_wen}, 32'd0);

    data_sram_rdata = 32'h80FF7F01;
    load(3'b001, 2'd3); chk("lb3", rf_wdata, 32'hFFFFFF80);
    load(3'b001, 2'd0); chk("lb0", rf_wdata, 32'h00000001);
    load(3'b010, 2'd3); chk("lbu3", rf_wdata, 32'h00000080);
    load(3'b010, 2'd2); chk("lbu2", rf_wdata, 32'h000000FF);
    load(3'b011, 2'd2); chk("lh2", rf_wdata, 32'hFFFF80FF);
    load(3'b011, 2'd0); chk("lh0", rf_wdata, 32'h00007F01);
    load(3'b100, 2'd0); chk("lhu0", rf_wdata, 32'h00007F01);
    load(3'b100, 2'd2); chk("lhu2", rf_wdata, 32'h000080FF);
    load(3'b000, 2'd0); chk("lw", rf_wdata, 32'h80FF7F01);
    chk("lw_we", {31'd0, rf_we}, 32'd1);

    clr();
    bus.ms_to_ws_valid = 1; bus.ms_HI_write = 1; bus.ms_LO_write = 1; bus.ms_hilo_src = 1;
    bus.ms_hi_result = 32'hAAAA0001; bus.ms_lo_result = 32'h55550002; bus.ms_alu_result = 32'h0000DEAD;
    issue();
    chk("mult_we", {31'd0, rf_we}, 32'd0);
    chk("mult_hi_pre", hi_value, 32'd0);
    clr();
    bus.ms_to_ws_valid = 1; bus.ms_memToReg = 2'b01; bus.ms_HI_read = 1; bus.ms_regwrite = 1; bus.ms_dest = 5'd2;
    issue();
    chk("mfhi_wdata", rf_wdata, 32'hAAAA0001);
    chk("mult_hi", hi_value, 32'hAAAA0001);
    chk("mult_lo", lo_value, 32'h55550002);
    clr();
    bus.ms_to_ws_valid = 1; bus.ms_memToReg = 2'b01; bus.ms_LO_read = 1; bus.ms_regwrite = 1; bus.ms_dest = 5'd3;
    issue();
    chk("mflo_wdata", rf_wdata, 32'h55550002);
    clr();
    bus.ms_to_ws_valid = 1; bus.ms_LO_write = 1; bus.ms_alu_result = 32'd7; bus.ms_lo_result = 32'h99999999;
    issue();
    clr();
    issue();
    chk("mtlo_lo", lo_value, 32'd7);
    chk("mtlo_hi", hi_value, 32'hAAAA0001);
    issue();
    chk("bubble_hold_lo", lo_value, 32'd7);

    bus.ms_to_ws_valid = 1; bus.ms_memToReg = 2'b10; bus.ms_regwrite = 1; bus.ms_dest = 5'd31; bus.ms_pc = 32'hBFC00100;
    issue();
    chk("jal_wdata", rf_wdata, 32'hBFC00108);
    chk("jal_waddr", {27'd0, rf_waddr}, 32'd31);
    chk("jal_pc", debug_wb_pc, 32'hBFC00100);
    bus.ms_memToReg = 2'b11; bus.ms_dest = 5'd4; bus.ms_cp0_rdata = 32'h0000FF01;
    issue();
    chk("mfc0_wdata", rf_wdata, 32'h0000FF01);
    bus.ms_memToReg = 2'b10; bus.ms_pc = 32'hFFFFFFFC;
    issue();
    chk("pc_wrap", rf_wdata, 32'h00000004);

    clr();
    bus.ms_to_ws_valid = 1; bus.ms_HI_write = 1; bus.ms_alu_result = 32'h00001234;
    bus.ms_regwrite = 1; bus.ms_dest = 5'd9;
    issue();
    chk("mthi_we", {31'd0, rf_we}, 32'd1);
    #2 resetn = 0;
    #1;
    chk("midrst_we", {31'd0, rf_we}, 32'd0);
    chk("midrst_hi", hi_value, 32'd0);
    chk("midrst_lo", lo_value, 32'd0);
    clr();
    #1 resetn = 1;
    issue();
    chk("postrst_hi", hi_value, 32'd0);
    chk("postrst_we", {31'd0, rf_we}, 32'd0);
    bus.ms_to_ws_valid = 1; bus.ms_regwrite = 1; bus.ms_dest = 5'd6; bus.ms_alu_result = 32'h00000055;
    issue();
    chk("postrst_addu_we", {31'd0, rf_we}, 32'd1);
    chk("postrst_addu_wdata", rf_wdata, 32'h00000055);
    clr();
    issue();
    chk("final_hi", hi_value, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back pipeline stage of the five-stage MIPS core. It accepts one instruction per cycle from the MEM stage, together with the control bits produced by the write-back control decoder (memToReg, regwrite, HI/LO read/write). It owns the architectural HI/LO registers, aligns and extends load data, and drives the register-file write port, the forwarding copy of it, and the debug trace port.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- ms_to_ws_valid  in  1  MEM holds a valid instruction for WB
- ws_allowin  out  1  WB can accept an instruction this cycle
- ms_pc  in  32  PC of the incoming instruction
- ms_memToReg  in  2  00 MEM result, 01 HI/LO, 10 PC+8, 11 CP0
- ms_regwrite  in  1  instruction writes the GPR file
- ms_HI_read / ms_LO_read  in  1 each  the 01 source is HI or LO
- ms_HI_write / ms_LO_write  in  1 each  instruction writes HI or LO
- ms_hilo_src  in  1  1: HI/LO take ms_hi_result/ms_lo_result (MULT/DIV); 0: take ms_alu_result (MTHI/MTLO)
- ms_dest  in  5  destination GPR
- ms_alu_result  in  32  ALU result; also the load address (bits [1:0] used)
- ms_hi_result / ms_lo_result  in  32 each  multiply/divide results
- ms_is_load  in  1  instruction is a load
- ms_load_type  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
- ms_cp0_rdata  in  32  MFC0 value, captured by MEM
- data_sram_rdata  in  32  synchronous SRAM read data; valid in the cycle the load occupies WB
- rf_we  out  1  GPR write enable; also the forwarding valid
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- hi_value / lo_value  out  32 each  committed HI/LO contents
- debug_wb_pc  out  32  trace PC
- debug_wb_rf_wen  out  4  trace write strobe ({4{rf_we}})
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

## Operation
- One-entry stage register. ws_ready_go is always 1, so ws_allowin = !ws_valid || ws_ready_go, which is always 1.
- Capture: on ms_to_ws_valid && ws_allowin, latch every ms_* input and set ws_valid = 1. Otherwise ws_valid = 0.
- Load data is little-endian and selected by the captured alu_result[1:0]:
  - LB/LBU: byte = rdata[8*a+7 : 8*a]. LB sign-extends; LBU zero-extends.
  - LH/LHU: half = a[1] ? rdata[31:16] : rdata[15:0]. LH sign-extends; LHU zero-extends. a[0] is ignored because alignment faults are raised upstream.
  - LW: rdata unchanged.
- Write-back data by memToReg:
  - 00: the extracted load data if is_load, otherwise alu_result.
  - 01: HI if HI_read, otherwise LO.
  - 10: pc + 32'd8, modulo 2^32.
  - 11: cp0_rdata.
- rf_we = ws_valid && regwrite && (dest != 0). rf_waddr = dest and rf_wdata = the selected data, driven regardless of rf_we.
- HI/LO update: on a rising edge with ws_valid && HI_write, HI <= hilo_src ? hi_result : alu_result. LO is updated the same way from LO_write. MULT/DIV assert both writes in the same cycle.
- MFHI/MFLO read the register value present during the WB cycle. A HI/LO write by the immediately preceding instruction is already committed by then.
- hi_value/lo_value are the registers themselves. Hazards against HI/LO in earlier stages are resolved upstream.
- Debug trace: debug_wb_pc = captured pc, debug_wb_rf_wen = {4{rf_we}}, debug_wb_rf_wnum = rf_waddr, debug_wb_rf_wdata = rf_wdata.

## Timing
- Reset (resetn low, asynchronous): ws_valid = 0 and HI = LO = 0. All captured fields are cleared to 0, so rf_we = 0, rf_waddr = 0, rf_wdata = 0, debug_wb_pc = 0 and debug_wb_rf_wen = 4'b0000.
- ws_allowin is 1 from reset onward.
- Latency: an instruction handed over at edge N drives rf_* combinationally during cycle N to N+1. The regfile commits at edge N+1, and any HI/LO write also commits at edge N+1.
- data_sram_rdata is used combinationally during the WB cycle and is never registered here.
- A bubble (ms_to_ws_valid = 0) clears ws_valid, so rf_we = 0 and HI/LO hold.
- Back-to-back instructions retire one per cycle with no stall.
- Reset asserted mid-instruction: the write is dropped immediately, and HI/LO revert to 0 even if a write was pending.

## Test plan
- Reset then idle: resetn low → all outputs 0 and ws_allowin = 1. Release with ms_to_ws_valid = 0 → rf_we stays 0 and hi_value = lo_value = 0.
- ADDU: dest = 5, alu_result = 0x12345678, memToReg = 00, regwrite = 1 → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x12345678, debug_wb_rf_wen = 4'hF. Repeat with dest = 0 → rf_we = 0.
- Loads with rdata = 0x80FF7F01:
  - LB at addr[1:0] = 3 → 0xFFFFFF80.
  - LBU at 3 → 0x00000080.
  - LH at 2 → 0xFFFF80FF.
  - LHU at 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- MULT then MFHI/MFLO: MULT with hilo_src = 1, hi = 0xAAAA0001, lo = 0x55550002 → HI/LO updated at the next edge with rf_we = 0. The following MFHI (memToReg = 01, HI_read) gives rf_wdata = 0xAAAA0001; the following MFLO gives 0x55550002. MTLO with alu_result = 7 → LO = 7 and HI unchanged.
- JAL/MFC0: pc = 0xBFC00100, memToReg = 10, dest = 31 → rf_wdata = 0xBFC00108. MFC0 with cp0_rdata = 0x0000FF01 → rf_wdata = 0x0000FF01. PC wrap: pc = 0xFFFFFFFC → 0x00000004.
- Reset mid-stream: pulse resetn low asynchronously (not on an edge) while an MTHI is in WB → rf_we drops at once, HI = 0 after release, and the next instruction retires normally.
